// File: rtl/rs_pool_pkg.sv
// ---------------------------------------------------------------------------
// rs_pool_pkg -- shared types and constants for the reservation-station pool.
//
// Holds the width constants used by the pool, its interface and its picker,
// the per-entry record and the operand wakeup helper.
//
// Optional feature macro: RS_AGE_SELECT_EN
//   defined   -> every entry carries a dispatch sequence stamp and the picker
//                issues the oldest ready entry.
//   undefined -> no stamp storage; the picker issues the lowest-index entry.
//
// The entry record is sized from the constants below, so any width or depth
// override of rs_pool must be mirrored here.
// ---------------------------------------------------------------------------
package rs_pool_pkg;

  localparam int RS_DATA_W    = 32;
  localparam int RS_ROB_ID_W  = 4;
  localparam int RS_OPNUM_W   = 6;
  localparam int RS_DEPTH_DEF = 16;
  // One extra bit over the index width so two live stamps can be ordered
  // across counter wrap.
  localparam int RS_STAMP_W   = $clog2(RS_DEPTH_DEF) + 1;

  typedef logic [RS_DATA_W-1:0]   data_t;
  typedef logic [RS_ROB_ID_W-1:0] rob_id_t;
  typedef logic [RS_OPNUM_W-1:0]  opnum_t;
  typedef logic [RS_STAMP_W-1:0]  stamp_t;

  // Tag q == 0 means the value v is already available.
  typedef struct packed {
    rob_id_t q;
    data_t   v;
  } operand_t;

  typedef struct packed {
    logic    valid;
    opnum_t  opnum;
    data_t   v1;
    data_t   v2;
    rob_id_t q1;
    rob_id_t q2;
    data_t   pc;
    data_t   imm;
    rob_id_t rob_id;
`ifdef RS_AGE_SELECT_EN
    stamp_t  stamp;
`endif
  } rs_entry_t;

  // Capture a broadcast result into a waiting operand. Operands that are
  // already ready (q == 0) never match, so a tag-0 broadcast is harmless.
  function automatic operand_t snoop(
    input operand_t op,
    input logic     rs_valid,
    input rob_id_t  rs_tag,
    input data_t    rs_data,
    input logic     ls_valid,
    input rob_id_t  ls_tag,
    input data_t    ls_data
  );
    operand_t res;
    res = op;
    if (op.q != '0) begin
      if (rs_valid && (rs_tag == op.q)) begin
        res.v = rs_data;
        res.q = '0;
      end else if (ls_valid && (ls_tag == op.q)) begin
        res.v = ls_data;
        res.q = '0;
      end
    end
    return res;
  endfunction

`ifdef RS_AGE_SELECT_EN
  // a is older than b when b lies less than half the stamp space ahead of a.
  function automatic logic stamp_older(input stamp_t a, input stamp_t b);
    stamp_t diff;
    diff = b - a;
    return (diff != '0) && !diff[RS_STAMP_W-1];
  endfunction
`endif

endpackage

// File: rtl/rs_pool_if.sv
// ---------------------------------------------------------------------------
// rs_pool_if -- bundle of every non-clock signal of the reservation-station
// pool.
//
//   dispatch in   : enable_sign_from_cmd, opnum/V1/V2/Q1/Q2/pc/imm/rob_id_from_cmd
//   alu bcast in  : valid_sign_from_rs_ex, rob_id_from_rs_ex, data_from_rs_ex
//   ls bcast in   : valid_sign_from_ls_ex, rob_id_from_ls_ex, data_from_ls_ex
//   flush in      : rollback_sign_from_rob
//   issue out     : valid_sign_to_rs_ex, opnum/V1/V2/pc/imm_to_rs_ex, rob_id
//   backpressure  : full_sign_to_if
//
// Modports: master = the surroundings driving the pool, slave = rs_pool.
// ---------------------------------------------------------------------------
interface rs_pool_if;
  import rs_pool_pkg::*;

  logic    enable_sign_from_cmd;
  opnum_t  opnum_from_cmd;
  data_t   V1_from_cmd;
  data_t   V2_from_cmd;
  rob_id_t Q1_from_cmd;
  rob_id_t Q2_from_cmd;
  data_t   pc_from_cmd;
  data_t   imm_from_cmd;
  rob_id_t rob_id_from_cmd;

  logic    valid_sign_from_rs_ex;
  rob_id_t rob_id_from_rs_ex;
  data_t   data_from_rs_ex;

  logic    valid_sign_from_ls_ex;
  rob_id_t rob_id_from_ls_ex;
  data_t   data_from_ls_ex;

  logic    rollback_sign_from_rob;

  logic    valid_sign_to_rs_ex;
  opnum_t  opnum_to_rs_ex;
  data_t   V1_to_rs_ex;
  data_t   V2_to_rs_ex;
  data_t   pc_to_rs_ex;
  data_t   imm_to_rs_ex;
  rob_id_t rob_id;

  logic    full_sign_to_if;

  modport master (
    output enable_sign_from_cmd, opnum_from_cmd, V1_from_cmd, V2_from_cmd,
           Q1_from_cmd, Q2_from_cmd, pc_from_cmd, imm_from_cmd, rob_id_from_cmd,
           valid_sign_from_rs_ex, rob_id_from_rs_ex, data_from_rs_ex,
           valid_sign_from_ls_ex, rob_id_from_ls_ex, data_from_ls_ex,
           rollback_sign_from_rob,
    input  valid_sign_to_rs_ex, opnum_to_rs_ex, V1_to_rs_ex, V2_to_rs_ex,
           pc_to_rs_ex, imm_to_rs_ex, rob_id, full_sign_to_if
  );

  modport slave (
    input  enable_sign_from_cmd, opnum_from_cmd, V1_from_cmd, V2_from_cmd,
           Q1_from_cmd, Q2_from_cmd, pc_from_cmd, imm_from_cmd, rob_id_from_cmd,
           valid_sign_from_rs_ex, rob_id_from_rs_ex, data_from_rs_ex,
           valid_sign_from_ls_ex, rob_id_from_ls_ex, data_from_ls_ex,
           rollback_sign_from_rob,
    output valid_sign_to_rs_ex, opnum_to_rs_ex, V1_to_rs_ex, V2_to_rs_ex,
           pc_to_rs_ex, imm_to_rs_ex, rob_id, full_sign_to_if
  );

endinterface

// File: rtl/rs_pick.sv
// ---------------------------------------------------------------------------
// rs_pick -- chooses which ready entry issues this cycle (purely combinational).
//
// Ports:
//   ready  in  DEPTH          one bit per entry that may issue now
//   stamp  in  DEPTH x stamp  dispatch stamps (only with RS_AGE_SELECT_EN)
//   found  out 1              at least one entry is ready
//   idx    out log2(DEPTH)    selected entry (0 when nothing is ready)
//
// Macro RS_AGE_SELECT_EN selects oldest-first; otherwise lowest index wins.
// ---------------------------------------------------------------------------
module rs_pick
  import rs_pool_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]         ready,
`ifdef RS_AGE_SELECT_EN
  input  stamp_t                   stamp [DEPTH],
`endif
  output logic                     found,
  output logic [$clog2(DEPTH)-1:0] idx
);

  localparam int IDX_W = $clog2(DEPTH);

`ifdef RS_AGE_SELECT_EN
  stamp_t best;

  // Linear scan keeping the oldest candidate seen so far.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    best  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!found || stamp_older(stamp[i], best))) begin
        found = 1'b1;
        idx   = i[IDX_W-1:0];
        best  = stamp[i];
      end
    end
  end
`else
  // First ready bit from index 0 upward.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && !found) begin
        found = 1'b1;
        idx   = i[IDX_W-1:0];
      end
    end
  end
`endif

endmodule

// File: rtl/rs_pool.sv
// ---------------------------------------------------------------------------
// rs_pool -- reservation-station pool: accepts dispatched micro-ops, snoops
// the two result broadcast buses to wake waiting operands, and issues one
// ready op per cycle into registered outputs.
//
// Ports:
//   clk  in  1   rising-edge clock
//   rst  in  1   synchronous, active-low reset
//   rdy  in  1   global enable; low freezes every register
//   bus  slave   rs_pool_if (dispatch, broadcasts, rollback, issue, full)
//
// Macro RS_AGE_SELECT_EN: issue the oldest ready entry using per-entry
// dispatch stamps; undefined, the lowest-index ready entry issues.
// ---------------------------------------------------------------------------
module rs_pool
  import rs_pool_pkg::*;
#(
  parameter int RS_DEPTH    = RS_DEPTH_DEF,
  parameter int DATA_W      = RS_DATA_W,
  parameter int ROB_ID_W    = RS_ROB_ID_W,
  parameter int OPNUM_W     = RS_OPNUM_W,
  parameter int FULL_MARGIN = 2
) (
  input logic   clk,
  input logic   rst,
  input logic   rdy,
  rs_pool_if.slave bus
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = $clog2(RS_DEPTH + 1);

  rs_entry_t ent      [RS_DEPTH];
  rs_entry_t ent_next [RS_DEPTH];

  logic [CNT_W-1:0]    occ;
  logic [CNT_W-1:0]    occ_next;

  logic [RS_DEPTH-1:0] ready_vec;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic                free_found;
  logic [IDX_W-1:0]    free_idx;
  logic                do_issue;
  logic                accept;
  rs_entry_t           new_entry;

  logic                issue_q;
  logic [OPNUM_W-1:0]  opnum_q;
  logic [DATA_W-1:0]   v1_q;
  logic [DATA_W-1:0]   v2_q;
  logic [DATA_W-1:0]   pc_q;
  logic [DATA_W-1:0]   imm_q;
  logic [ROB_ID_W-1:0] rob_q;

`ifdef RS_AGE_SELECT_EN
  stamp_t seq;
  stamp_t stamp_vec [RS_DEPTH];
`endif

  // Ready = occupied with both operands available. The lowest free slot is
  // searched from the pre-edge valids, so a slot issuing this edge is not
  // reused until the next one.
  always_comb begin
    ready_vec  = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      ready_vec[i] = ent[i].valid && (ent[i].q1 == '0) && (ent[i].q2 == '0);
      if (!ent[i].valid && !free_found) begin
        free_found = 1'b1;
        free_idx   = i[IDX_W-1:0];
      end
    end
  end

`ifdef RS_AGE_SELECT_EN
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      stamp_vec[i] = ent[i].stamp;
    end
  end
`endif

  rs_pick #(
    .DEPTH (RS_DEPTH)
  ) u_pick (
    .ready (ready_vec),
`ifdef RS_AGE_SELECT_EN
    .stamp (stamp_vec),
`endif
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Rollback wins over both issue and dispatch in the same cycle.
  assign do_issue = pick_found && !bus.rollback_sign_from_rob;
  assign accept   = bus.enable_sign_from_cmd && free_found && !bus.rollback_sign_from_rob;

  // Incoming op, with its operands already snooped against this cycle's
  // broadcasts so a result produced alongside dispatch is not missed.
  always_comb begin : build_entry
    operand_t op_a;
    operand_t op_b;
    op_a = snoop({bus.Q1_from_cmd, bus.V1_from_cmd},
                 bus.valid_sign_from_rs_ex, bus.rob_id_from_rs_ex, bus.data_from_rs_ex,
                 bus.valid_sign_from_ls_ex, bus.rob_id_from_ls_ex, bus.data_from_ls_ex);
    op_b = snoop({bus.Q2_from_cmd, bus.V2_from_cmd},
                 bus.valid_sign_from_rs_ex, bus.rob_id_from_rs_ex, bus.data_from_rs_ex,
                 bus.valid_sign_from_ls_ex, bus.rob_id_from_ls_ex, bus.data_from_ls_ex);
    new_entry        = '0;
    new_entry.valid  = 1'b1;
    new_entry.opnum  = bus.opnum_from_cmd;
    new_entry.v1     = op_a.v;
    new_entry.q1     = op_a.q;
    new_entry.v2     = op_b.v;
    new_entry.q2     = op_b.q;
    new_entry.pc     = bus.pc_from_cmd;
    new_entry.imm    = bus.imm_from_cmd;
    new_entry.rob_id = bus.rob_id_from_cmd;
`ifdef RS_AGE_SELECT_EN
    new_entry.stamp  = seq;
`endif
  end

  // Next pool contents: wakeup of resident entries, release of the issued
  // slot, then the dispatch write; rollback simply empties the pool.
  always_comb begin : next_state
    operand_t op_a;
    operand_t op_b;
    op_a     = '0;
    op_b     = '0;
    ent_next = ent;
    occ_next = occ;
    if (bus.rollback_sign_from_rob) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_next[i].valid = 1'b0;
      end
      occ_next = '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        op_a = snoop({ent[i].q1, ent[i].v1},
                     bus.valid_sign_from_rs_ex, bus.rob_id_from_rs_ex, bus.data_from_rs_ex,
                     bus.valid_sign_from_ls_ex, bus.rob_id_from_ls_ex, bus.data_from_ls_ex);
        op_b = snoop({ent[i].q2, ent[i].v2},
                     bus.valid_sign_from_rs_ex, bus.rob_id_from_rs_ex, bus.data_from_rs_ex,
                     bus.valid_sign_from_ls_ex, bus.rob_id_from_ls_ex, bus.data_from_ls_ex);
        ent_next[i].q1 = op_a.q;
        ent_next[i].v1 = op_a.v;
        ent_next[i].q2 = op_b.q;
        ent_next[i].v2 = op_b.v;
      end
      if (do_issue) begin
        ent_next[pick_idx].valid = 1'b0;
      end
      if (accept) begin
        ent_next[free_idx] = new_entry;
      end
      occ_next = occ + CNT_W'(accept) - CNT_W'(do_issue);
    end
  end

  // State and issue registers. rdy low freezes everything except the issue
  // strobe, which drops so a held op is never presented twice.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent[i] <= '0;
      end
      occ     <= '0;
      issue_q <= 1'b0;
      opnum_q <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      rob_q   <= '0;
`ifdef RS_AGE_SELECT_EN
      seq     <= '0;
`endif
    end else if (rdy) begin
      ent     <= ent_next;
      occ     <= occ_next;
      issue_q <= do_issue;
      if (do_issue) begin
        opnum_q <= ent[pick_idx].opnum;
        v1_q    <= ent[pick_idx].v1;
        v2_q    <= ent[pick_idx].v2;
        pc_q    <= ent[pick_idx].pc;
        imm_q   <= ent[pick_idx].imm;
        rob_q   <= ent[pick_idx].rob_id;
      end
`ifdef RS_AGE_SELECT_EN
      if (accept) begin
        seq <= seq + 1'b1;
      end
`endif
    end else begin
      issue_q <= 1'b0;
    end
  end

  assign bus.valid_sign_to_rs_ex = issue_q;
  assign bus.opnum_to_rs_ex      = opnum_q;
  assign bus.V1_to_rs_ex         = v1_q;
  assign bus.V2_to_rs_ex         = v2_q;
  assign bus.pc_to_rs_ex         = pc_q;
  assign bus.imm_to_rs_ex        = imm_q;
  assign bus.rob_id              = rob_q;

  // Free entries below the margin raises backpressure one dispatch early.
  assign bus.full_sign_to_if = (int'(occ) > (RS_DEPTH - FULL_MARGIN));

endmodule

// File: doc/rs_pool.md
RS_POOL -- requirements
Module: rs_pool

Interface
REQ-001 SHALL have parameter RS_DEPTH, default 16, entry count (power of two, 2..32).
REQ-002 SHALL have parameter DATA_W, default 32, operand/pc/imm width.
REQ-003 SHALL have parameter ROB_ID_W, default 4, ROB tag width; tag 0 means "operand ready".
REQ-004 SHALL have parameter OPNUM_W, default 6, opcode width.
REQ-005 SHALL have parameter FULL_MARGIN, default 2, free-entry threshold for full_sign_to_if.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 rst  in  1  synchronous, active-low reset.
REQ-008 rdy  in  1  global enable; low freezes all state.
REQ-009 enable_sign_from_cmd  in  1  dispatch strobe.
REQ-010 opnum_from_cmd, V1_from_cmd, V2_from_cmd, Q1_from_cmd, Q2_from_cmd, pc_from_cmd, imm_from_cmd, rob_id_from_cmd  in  OPNUM_W/DATA_W/ROB_ID_W  dispatched micro-op fields.
REQ-011 valid_sign_from_rs_ex, rob_id_from_rs_ex, data_from_rs_ex  in  1/ROB_ID_W/DATA_W  ALU result broadcast.
REQ-012 valid_sign_from_ls_ex, rob_id_from_ls_ex, data_from_ls_ex  in  1/ROB_ID_W/DATA_W  load/store result broadcast.
REQ-013 rollback_sign_from_rob  in  1  misprediction flush.
REQ-014 valid_sign_to_rs_ex  out  1  issue strobe, one cycle per issued op.
REQ-015 opnum_to_rs_ex, V1_to_rs_ex, V2_to_rs_ex, pc_to_rs_ex, imm_to_rs_ex, rob_id  out  OPNUM_W/DATA_W/ROB_ID_W  issued op fields, registered.
REQ-016 full_sign_to_if  out  1  high when free entries < FULL_MARGIN.

Function
REQ-017 Dispatch sampled at edge E SHALL write the lowest-index free entry; entry valid from E.
REQ-018 A broadcast (either port) whose tag equals a nonzero entry Q SHALL, at that edge, load V from data and clear Q to 0; both ports SHALL be applied in the same edge.
REQ-019 Dispatch bypass: if Q1/Q2_from_cmd matches a same-cycle broadcast, the entry SHALL be written with the broadcast data and Q=0.
REQ-020 An entry is ready when valid and Q1==Q2==0; at each edge one ready entry SHALL issue: output registers load its fields, valid_sign_to_rs_ex=1 for the following cycle, entry freed.
REQ-021 No ready entry at an edge SHALL give valid_sign_to_rs_ex=0 next cycle; other outputs hold.
REQ-022 Minimum latency: dispatch at edge E with Q1=Q2=0 SHALL issue at edge E+1; wakeup at edge E SHALL allow issue at E+1.
REQ-023 Occupancy counter SHALL update as +1 dispatch, -1 issue, unchanged when both occur in one edge.
REQ-024 Dispatch while no entry free SHALL be dropped (upstream error); full_sign_to_if SHALL be combinational from occupancy.
REQ-025 rollback_sign_from_rob at edge E SHALL invalidate all entries, zero occupancy, force valid_sign_to_rs_ex=0, and override same-cycle dispatch and issue.
REQ-026 rdy low SHALL hold all entries, counter and output fields; valid_sign_to_rs_ex SHALL be 0 while rdy low.

Reset
REQ-027 rst low at an edge SHALL clear all entry valids, occupancy and age state, and drive every output register to 0; full_sign_to_if then 0 (FULL_MARGIN<=RS_DEPTH).
REQ-028 Reset SHALL take priority over rollback, dispatch and issue.

Configuration
REQ-029 Macro RS_AGE_SELECT_EN defined: each entry SHALL keep a dispatch sequence stamp and issue SHALL pick the oldest ready entry (wrap-safe compare, stamp width clog2(RS_DEPTH)+1).
REQ-030 RS_AGE_SELECT_EN undefined: issue SHALL pick the lowest-index ready entry; no stamp storage.

Structure
REQ-031 Shared package SHALL hold ROB-id, data, opnum width constants and the entry record typedef (valid, opnum, V1, V2, Q1, Q2, pc, imm, rob_id, stamp).
REQ-032 Sub-module rs_pick SHALL implement the ready-vector to index selection (priority or age).

Verification
REQ-033 Dispatch ADD Q1=Q2=0 V1=5 V2=7 rob 3 -> next edge issue, V1_to_rs_ex=5, V2_to_rs_ex=7, rob_id=3, strobe one cycle.
REQ-034 Dispatch Q1=4; later ls_ex broadcast rob 4 data 0x1234 -> issue next edge with V1=0x1234.
REQ-035 Dispatch Q2=6 in same cycle as rs_ex broadcast rob 6 data 9 -> stored V2=9, issues next edge.
REQ-036 Fill RS_DEPTH-1 blocked entries -> full_sign_to_if=1; rollback -> all freed, full=0, no issue.
REQ-037 With RS_AGE_SELECT_EN, entries at index 5 (older) and 1 (younger) woken together -> index 5 issues first.
